// File: rtl/seq_det_pkg.sv
// Shared definitions for the parameterised serial sequence detector:
// FSM state encoding and the pattern loaded at reset.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    localparam logic [4:0] SEQ_DEFAULT_PATTERN = 5'b10110;

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating event counter; a clear wins over a simultaneous increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != MAX) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: W-bit sliding window compared against a loadable
// pattern, with optional overlap, registered match pulse and saturating count.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int             W               = 5,
    parameter int             CNT_W           = 8,
    parameter logic [W-1:0]   DEFAULT_PATTERN = W'(SEQ_DEFAULT_PATTERN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             overlap,
    input  logic             cfg_load,
    input  logic [W-1:0]     cfg_pattern,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic [1:0]       state
);

    if (W < 2 || W > 16 || CNT_W < 1) begin : g_bad_param
        $error("seq_detector_param: W must be 2..16 and CNT_W >= 1");
    end

    localparam int              FILL_W = $clog2(W + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(W);

    state_t              state_q, state_d;
    logic [W-1:0]        pattern_q, pattern_d;
    logic [W-1:0]        hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                match_q, match_d;

    logic [W-1:0]        hist_shift;
    logic [FILL_W-1:0]   fill_inc;
    logic                hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pattern_q <= DEFAULT_PATTERN;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
        end
    end

    always_comb begin
        hist_shift = {hist_q[W-2:0], din};
        fill_inc   = (fill_q == FULL) ? FULL : fill_q + 1'b1;
        // A load on the same edge discards din, so it can never complete a match.
        hit        = en && !cfg_load && (hist_shift == pattern_q) && (fill_inc == FULL);

        state_d    = state_q;
        pattern_d  = pattern_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        match_d    = 1'b0;

        if (cfg_load) begin
            pattern_d = cfg_pattern;
            hist_d    = '0;
            fill_d    = '0;
            state_d   = IDLE;
        end else if (en) begin
            hist_d  = hist_shift;
            match_d = hit;
            if (hit && !overlap) begin
                // Non-overlapping mode: the next W accepted bits form a fresh window.
                fill_d  = '0;
                state_d = FILL;
            end else begin
                fill_d  = fill_inc;
                state_d = (fill_inc == FULL) ? ARMED : FILL;
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit),
        .clr   (cnt_clr),
        .count (match_cnt)
    );

    assign match = match_q;
    assign state = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Table-driven bench for seq_detector_param: two instances (CNT_W=8 and 2)
// share stimulus; expected outputs flow through a scoreboard queue.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, din, overlap, cfg_load, cnt_clr;
    logic [4:0] cfg_pattern;

    logic       match_a, match_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [1:0] state_a, state_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.W(5), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr),
        .match(match_a), .match_cnt(cnt_a), .state(state_a)
    );

    seq_detector_param #(.W(5), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr),
        .match(match_b), .match_cnt(cnt_b), .state(state_b)
    );

    typedef struct {
        logic       en;
        logic       din;
        logic       ov;
        logic       cfg;
        logic [4:0] pat;
        logic       clr;
        logic       m;
        logic [7:0] ca;
        logic [1:0] cb;
        logic [1:0] st;
        string      name;
    } row_t;

    row_t rows[$];
    row_t exp_q[$];

    task automatic add(input logic e, input logic d, input logic ov, input logic cfg,
                       input logic [4:0] pat, input logic clr, input logic m,
                       input logic [7:0] ca, input logic [1:0] cb, input logic [1:0] st,
                       input string name);
        row_t r;
        r.en = e; r.din = d; r.ov = ov; r.cfg = cfg; r.pat = pat; r.clr = clr;
        r.m = m; r.ca = ca; r.cb = cb; r.st = st; r.name = name;
        rows.push_back(r);
    endtask

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_row(input row_t r);
        row_t e;
        @(negedge clk);
        en = r.en; din = r.din; overlap = r.ov;
        cfg_load = r.cfg; cfg_pattern = r.pat; cnt_clr = r.clr;
        exp_q.push_back(r);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({e.name, " match_a"}, int'(match_a), int'(e.m));
        check({e.name, " match_b"}, int'(match_b), int'(e.m));
        check({e.name, " cnt_a"},   int'(cnt_a),   int'(e.ca));
        check({e.name, " cnt_b"},   int'(cnt_b),   int'(e.cb));
        check({e.name, " state_a"}, int'(state_a), int'(e.st));
        check({e.name, " state_b"}, int'(state_b), int'(e.st));
    endtask

    initial begin
        int split;
        int k;

        // ---- default pattern 10110, overlap=1, stream 10110110
        add(1,1,1,0,5'b0,0, 0,0,0,1, "ov1 b1");
        add(1,0,1,0,5'b0,0, 0,0,0,1, "ov1 b2");
        add(1,1,1,0,5'b0,0, 0,0,0,1, "ov1 b3");
        add(1,1,1,0,5'b0,0, 0,0,0,1, "ov1 b4");
        add(1,0,1,0,5'b0,0, 1,1,1,2, "ov1 b5");
        add(1,1,1,0,5'b0,0, 0,1,1,2, "ov1 b6");
        add(1,1,1,0,5'b0,0, 0,1,1,2, "ov1 b7");
        add(1,0,1,0,5'b0,0, 1,2,2,2, "ov1 b8");
        add(0,1,1,0,5'b0,0, 0,2,2,2, "en0 after match");
        // ---- restart, same stream with overlap=0; load with en=1 discards din
        add(1,1,0,1,5'b10110,0, 0,2,2,0, "load 10110");
        add(1,1,0,0,5'b0,0, 0,2,2,1, "ov0 b1");
        add(1,0,0,0,5'b0,0, 0,2,2,1, "ov0 b2");
        add(1,1,0,0,5'b0,0, 0,2,2,1, "ov0 b3");
        add(1,1,0,0,5'b0,0, 0,2,2,1, "ov0 b4");
        add(1,0,0,0,5'b0,0, 1,3,3,1, "ov0 b5");
        add(1,1,0,0,5'b0,0, 0,3,3,1, "ov0 b6");
        add(1,1,0,0,5'b0,0, 0,3,3,1, "ov0 b7");
        add(1,0,0,0,5'b0,0, 0,3,3,1, "ov0 b8");
        // ---- count clear, then en gaps inside the pattern
        add(0,0,1,0,5'b0,1, 0,0,0,1, "cnt_clr");
        add(1,0,1,1,5'b10110,0, 0,0,0,0, "load gap");
        add(1,1,1,0,5'b0,0, 0,0,0,1, "gap b1");
        add(1,0,1,0,5'b0,0, 0,0,0,1, "gap b2");
        add(0,1,1,0,5'b0,0, 0,0,0,1, "gap idle1");
        add(0,0,1,0,5'b0,0, 0,0,0,1, "gap idle2");
        add(0,1,1,0,5'b0,0, 0,0,0,1, "gap idle3");
        add(1,1,1,0,5'b0,0, 0,0,0,1, "gap b3");
        add(1,1,1,0,5'b0,0, 0,0,0,1, "gap b4");
        add(1,0,1,0,5'b0,0, 1,1,1,2, "gap b5");
        // ---- all-ones pattern, back-to-back matches
        add(1,1,1,1,5'b11111,0, 0,1,1,0, "load 11111");
        for (int i = 1; i <= 8; i++) begin
            k = (i < 5) ? 0 : 1;
            add(1,1,1,0,5'b0,0, logic'(k), 8'(1 + ((i < 5) ? 0 : i - 4)),
                2'((1 + ((i < 5) ? 0 : i - 4)) > 3 ? 3 : (1 + ((i < 5) ? 0 : i - 4))),
                (i < 5) ? 2'd1 : 2'd2, $sformatf("ones8 b%0d", i));
        end
        // ---- load and clear together, then saturation of the narrow counter
        add(1,1,1,1,5'b11111,1, 0,0,0,0, "load+clr");
        for (int i = 1; i <= 12; i++) begin
            k = (i < 5) ? 0 : i - 4;
            add(1,1,1,0,5'b0,0, logic'(i >= 5), 8'(k), 2'(k > 3 ? 3 : k),
                (i < 5) ? 2'd1 : 2'd2, $sformatf("ones12 b%0d", i));
        end
        add(1,1,1,0,5'b0,1, 1,0,0,2, "clr with match");
        add(1,1,1,0,5'b0,0, 1,1,1,2, "match after clr");
        // ---- partial pattern before a reset
        add(0,0,1,1,5'b11111,0, 0,1,1,0, "load pre-rst");
        add(1,1,1,0,5'b0,0, 0,1,1,1, "pre-rst b1");
        add(1,0,1,0,5'b0,0, 0,1,1,1, "pre-rst b2");
        add(1,1,1,0,5'b0,0, 0,1,1,1, "pre-rst b3");
        add(1,1,1,0,5'b0,0, 0,1,1,1, "pre-rst b4");
        split = rows.size();
        // ---- after reset: lone 0 is bit 1; pattern must be back to 10110
        add(1,0,1,0,5'b0,0, 0,0,0,1, "post-rst b1");
        add(1,1,1,0,5'b0,0, 0,0,0,1, "post-rst b2");
        add(1,0,1,0,5'b0,0, 0,0,0,1, "post-rst b3");
        add(1,1,1,0,5'b0,0, 0,0,0,1, "post-rst b4");
        add(1,1,1,0,5'b0,0, 0,0,0,2, "post-rst b5");
        add(1,0,1,0,5'b0,0, 1,1,1,2, "post-rst b6");

        // Reset state
        rst_n = 1'b0; en = 0; din = 0; overlap = 0; cfg_load = 0; cnt_clr = 0;
        cfg_pattern = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst match_a", int'(match_a), 0);
        check("rst cnt_a",   int'(cnt_a),   0);
        check("rst state_a", int'(state_a), 0);
        check("rst cnt_b",   int'(cnt_b),   0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < split; i++) apply_row(rows[i]);

        // Asynchronous reset mid-pattern takes effect without a clock edge
        @(negedge clk);
        en = 0;
        rst_n = 1'b0;
        #1;
        check("async rst match_a", int'(match_a), 0);
        check("async rst cnt_a",   int'(cnt_a),   0);
        check("async rst cnt_b",   int'(cnt_b),   0);
        check("async rst state_a", int'(state_a), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = split; i < rows.size(); i++) apply_row(rows[i]);

        check("scoreboard empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
